jk_excitation_driver: RTL and testbench

- Drives the J/K inputs of an external bank of WIDTH JK flip-flops so the bank reaches a requested target value.
- Uses the JK excitation table against the bank's fed-back Q, then checks that the bank actually reached the target.
- Acts as the controlling end of the JK flop interface: it produces J/K from desired Q, where the flop produces Q from J/K.
- Placed beside any JK register bank as its self-checking writer.

---
 rtl/jk_pkg.sv | 23 ++
 rtl/jk_excite.sv | 21 ++
 rtl/jk_excitation_driver.sv | 112 +++++++++++
 tb/tb_jk_excitation_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for JK bank controllers: FSM states and per-bit {J,K} excitation codes.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // {J,K} needed to move one flop from q to t on the next edge
  function automatic logic [1:0] excite_bit(input logic q, input logic t, input logic toggle);
    if (q == t)      return JK_HOLD;
    else if (toggle) return JK_TOGGLE;
    else if (t)      return JK_SET;
    else             return JK_RESET;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation encoder: derives J/K per bit from current Q and desired Q.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit TOGGLE_MODE = 1'b0
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [1:0] w_jk;
    assign w_jk   = excite_bit(i_q[g], i_target[g], TOGGLE_MODE);
    assign o_j[g] = w_jk[1];
    assign o_k[g] = w_jk[0];
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Self-checking writer for an external JK register bank: drives J/K for one edge,
// then verifies the fed-back Q and keeps a saturating mismatch count.
//
// state | meaning
// IDLE  | ready for a target; J/K held at 0
// DRIVE | J/K presented to the bank, sampled at the next edge
// CHECK | bank has updated; compare q_fb with the captured target
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int TOGGLE_MODE = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] target_data,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             match,
  input  logic             clear_err,
  output logic [CNT_W-1:0] err_count
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             r_done;
  logic             r_match;
  logic [CNT_W-1:0] r_err;
  logic             w_accept;
  logic             w_mismatch;

  jk_excite #(
    .WIDTH      (WIDTH),
    .TOGGLE_MODE(TOGGLE_MODE != 0)
  ) u_excite (
    .i_q     (q_fb),
    .i_target(target_data),
    .o_j     (w_j),
    .o_k     (w_k)
  );

  always_comb begin
    w_next       = r_state;
    target_ready = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        target_ready = 1'b1;
        if (target_valid) begin
          w_accept = 1'b1;
          w_next   = DRIVE;
        end
      end
      DRIVE:   w_next = CHECK;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_mismatch = (r_state == CHECK) && (q_fb != r_tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_err   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_tgt <= target_data;
        r_j   <= w_j;
        r_k   <= w_k;
      end
      if (r_state == DRIVE) begin
        r_j <= '0;
        r_k <= '0;
      end
      if (r_state == CHECK) begin
        r_done  <= 1'b1;
        r_match <= (q_fb == r_tgt);
      end
      // a clear in the same cycle as a mismatch takes priority
      if (clear_err)                      r_err <= '0;
      else if (w_mismatch && r_err != '1) r_err <= r_err + CNT_W'(1);
    end
  end

  assign J         = r_j;
  assign K         = r_k;
  assign done      = r_done;
  assign match     = r_match;
  assign err_count = r_err;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: three drivers (set/reset, toggle, 2-bit counter) each writing its own modelled JK bank.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic rst;
  logic tv;
  logic clr;
  logic [3:0] td;
  logic [3:0] stuck;

  logic [3:0] j0, k0, j1, k1, j2, k2;
  logic [3:0] b0, b1, b2;
  logic [3:0] q0, q1, q2;
  logic rdy0, rdy1, rdy2, dn0, dn1, dn2, m0, m1, m2;
  logic [7:0] e0, e1;
  logic [1:0] e2;

  int total = 0;
  int bad = 0;
  int m_err[3];

  always #5 clk = ~clk;

  // stuck-at-0 bits are forced on the bank's visible outputs
  assign q0 = b0 & ~stuck;
  assign q1 = b1 & ~stuck;
  assign q2 = b2 & ~stuck;

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b0 <= '0; b1 <= '0; b2 <= '0;
    end else begin
      b0 <= jk_next(b0, j0, k0);
      b1 <= jk_next(b1, j1, k1);
      b2 <= jk_next(b2, j2, k2);
    end
  end

  jk_excitation_driver #(.WIDTH(4), .TOGGLE_MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .target_valid(tv), .target_ready(rdy0), .target_data(td),
    .J(j0), .K(k0), .q_fb(q0), .done(dn0), .match(m0), .clear_err(clr), .err_count(e0));
  jk_excitation_driver #(.WIDTH(4), .TOGGLE_MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .target_valid(tv), .target_ready(rdy1), .target_data(td),
    .J(j1), .K(k1), .q_fb(q1), .done(dn1), .match(m1), .clear_err(clr), .err_count(e1));
  jk_excitation_driver #(.WIDTH(4), .TOGGLE_MODE(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .target_valid(tv), .target_ready(rdy2), .target_data(td),
    .J(j2), .K(k2), .q_fb(q2), .done(dn2), .match(m2), .clear_err(clr), .err_count(e2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] st;
    bit         c;
    bit         em;
    int         ee2;
  } vec_t;

  // One full accept/drive/check transaction, checked at every negedge.
  task automatic run_txn(input logic [3:0] t, input logic [3:0] st, input bit c,
                         input bit use_tbl, input bit tem, input int tee2);
    logic [3:0] qa, qb, qc, fin;
    bit em;
    int mx[3];
    mx[0] = 255; mx[1] = 255; mx[2] = 3;
    @(negedge clk);
    stuck = st;
    #1;
    qa = q0; qb = q1; qc = q2;
    check("ready_idle", rdy0 & rdy1 & rdy2, 1);
    tv = 1'b1; td = t;
    @(negedge clk);
    check("ready_drive", {rdy0, rdy1, rdy2}, 0);
    check("j_setreset", j0, t & ~qa);
    check("k_setreset", k0, qa & ~t);
    check("j_toggle", j1, qb ^ t);
    check("k_toggle", k1, qb ^ t);
    check("j_cnt2", j2, t & ~qc);
    check("k_cnt2", k2, qc & ~t);
    tv = 1'b0; td = $urandom_range(0, 15);
    @(negedge clk);
    fin = t & ~st;
    check("jk_hold", {j0, k0, j1, k1, j2, k2}, 0);
    check("done_early", {dn0, dn1, dn2}, 0);
    check("bank_q0", q0, fin);
    check("bank_q1", q1, fin);
    check("bank_q2", q2, fin);
    clr = c;
    @(negedge clk);
    em = (fin == t);
    check("done", {dn0, dn1, dn2}, 3'b111);
    check("match", {m0, m1, m2}, {3{em}});
    for (int d = 0; d < 3; d++) begin
      if (c) m_err[d] = 0;
      else if (!em && m_err[d] < mx[d]) m_err[d]++;
    end
    check("err0", e0, m_err[0]);
    check("err1", e1, m_err[1]);
    check("err2", e2, m_err[2]);
    if (use_tbl) begin
      check("match_tbl", m0, tem);
      check("err2_tbl", e2, tee2);
    end
    clr = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b1010, 4'b0000, 0, 1, 0};
    tbl[1] = '{4'b0110, 4'b0000, 0, 1, 0};
    tbl[2] = '{4'b0110, 4'b0000, 0, 1, 0};
    tbl[3] = '{4'b0001, 4'b0001, 0, 0, 1};
    tbl[4] = '{4'b0001, 4'b0001, 1, 0, 0};
    tbl[5] = '{4'b0001, 4'b0001, 0, 0, 1};
    tbl[6] = '{4'b0001, 4'b0001, 0, 0, 2};
    tbl[7] = '{4'b0001, 4'b0001, 0, 0, 3};
    tbl[8] = '{4'b0001, 4'b0001, 0, 0, 3};
    tbl[9] = '{4'b0000, 4'b0000, 0, 1, 3};
    for (int d = 0; d < 3; d++) m_err[d] = 0;

    rst = 1'b1; tv = 1'b0; clr = 1'b0; td = '0; stuck = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_ready", rdy0 & rdy1 & rdy2, 1);
      check("rst_jk", {j0, k0, j1, k1, j2, k2}, 0);
      check("rst_done", {dn0, dn1, dn2}, 0);
      check("rst_err", {e0, e1, e2}, 0);
    end

    // reset during DRIVE
    tv = 1'b1; td = 4'b1111;
    @(negedge clk);
    check("pre_rst_j", j0, 4'b1111);
    rst = 1'b1;
    #1;
    check("midrst_jk", {j0, k0, j1, k1, j2, k2}, 0);
    check("midrst_done", {dn0, dn1, dn2}, 0);
    check("midrst_err", {e0, e1, e2}, 0);
    tv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", rdy0, 1);
    check("postrst_done", dn0, 0);
    @(negedge clk);
    check("postrst_nodone", dn0, 0);

    // target_valid held through DRIVE/CHECK must be accepted once per pass
    tv = 1'b1; td = 4'b0101;
    @(negedge clk);
    check("hold_drive_j", j0, 4'b0101);
    @(negedge clk);
    check("hold_check_ready", rdy0, 0);
    check("hold_check_j", j0, 0);
    check("hold_check_done", dn0, 0);
    @(negedge clk);
    check("hold_done", dn0, 1);
    check("hold_match", m0, 1);
    check("hold_ready", rdy0, 1);
    @(negedge clk);
    check("hold_reaccept", rdy0, 0);
    check("hold_reaccept_done", dn0, 0);
    check("hold_reaccept_j", j0, 0);
    tv = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_done2", dn0, 1);
    check("hold_match2", m0, 1);
    check("hold_err", e0, 0);

    foreach (tbl[i]) run_txn(tbl[i].tgt, tbl[i].st, tbl[i].c, 1'b1, tbl[i].em, tbl[i].ee2);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rt, rs;
      rt = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      run_txn(rt, rs, ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
